// File: rtl/bcd_mux7seg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bcd_mux7seg                                                   |
// | Purpose  : Time-multiplexed seven-segment driver for NDIG packed BCD     |
// |            digits. Each slot opens with an anti-ghosting blank interval; |
// |            inputs are snapshotted once per frame; optional leading-zero  |
// |            blanking. All outputs are registered.                        |
// | Ports    : clk        - clock, rising edge                               |
// |            reset_n    - asynchronous active-low reset                    |
// |            digits     - packed BCD, digit s at [4s+3:4s], 0 = LSD        |
// |            dp_mask    - decimal point enable per digit                   |
// |            lz_blank   - leading-zero blanking enable                     |
// |            seg        - segments a..g on bit0..bit6                      |
// |            dp         - decimal point                                    |
// |            an         - digit enables, an[s] drives slot s               |
// |            frame_tick - one-cycle pulse in the last cycle of a frame     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bcd_mux7seg #(
   parameter int NDIG       = 4,
   parameter int PRESCALE   = 1000,
   parameter int BLANK_CYC  = 50,
   parameter int ACTIVE_LOW = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [4*NDIG-1:0] digits,
   input  logic [NDIG-1:0]   dp_mask,
   input  logic              lz_blank,
   output logic [6:0]        seg,
   output logic              dp,
   output logic [NDIG-1:0]   an,
   output logic              frame_tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int SW = $clog2(NDIG);

   localparam logic [CW-1:0]   C_CNT_MAX  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0]   C_BLANK    = CW'(BLANK_CYC);
   localparam logic [SW-1:0]   C_SLOT_MAX = SW'(NDIG - 1);
   localparam logic [6:0]      C_SEG_INV  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic            C_DP_INV   = (ACTIVE_LOW != 0);
   localparam logic [NDIG-1:0] C_AN_INV   = (ACTIVE_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

   // Active-high segment pattern; non-BCD nibbles show a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   logic [CW-1:0]     cnt_q,  cnt_d;
   logic [SW-1:0]     slot_q, slot_d;
   logic [4*NDIG-1:0] dig_q,  dig_d;
   logic [NDIG-1:0]   dpm_q,  dpm_d;
   logic              lz_q,   lz_d;
   logic [6:0]        seg_q,  seg_d;
   logic              dp_q,   dp_d;
   logic [NDIG-1:0]   an_q,   an_d;
   logic              ft_q,   ft_d;

   logic [3:0]        w_nib_arr [NDIG];
   logic [NDIG-1:0]   w_zero_from;   // bit s: digits s..NDIG-1 are all zero
   logic              w_acc;
   logic              w_on;
   logic              w_blank;
   logic              w_dpv;

   for (genvar g = 0; g < NDIG; g++) begin : g_nib
      assign w_nib_arr[g] = dig_q[4*g +: 4];
   end

   always_comb begin
      w_zero_from = '0;
      w_acc       = 1'b1;
      for (int s = NDIG - 1; s >= 0; s--) begin
         w_acc          = w_acc & (w_nib_arr[s] == 4'd0);
         w_zero_from[s] = w_acc;
      end
   end

   // Counters and snapshot next-state.
   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      slot_d = slot_q;
      if (cnt_q == C_CNT_MAX) begin
         cnt_d  = '0;
         slot_d = (slot_q == C_SLOT_MAX) ? '0 : slot_q + 1'b1;
      end
      dig_d = dig_q;
      dpm_d = dpm_q;
      lz_d  = lz_q;
      // Loading here is safe: the cycle after this edge is cnt==1, which is
      // always inside the blank interval.
      if ((slot_q == '0) && (cnt_q == '0)) begin
         dig_d = digits;
         dpm_d = dp_mask;
         lz_d  = lz_blank;
      end
   end

   // Output next-state, evaluated for the state being entered so the
   // registered outputs line up with the current (slot, cnt).
   always_comb begin
      w_on    = (cnt_d >= C_BLANK);
      w_blank = lz_q && (slot_d != '0) && w_zero_from[slot_d];
      w_dpv   = dpm_q[slot_d];
      seg_d   = C_SEG_INV;
      dp_d    = C_DP_INV;
      an_d    = C_AN_INV;
      if (w_on) begin
         if (!w_blank) begin
            seg_d = seg_decode(w_nib_arr[slot_d]) ^ C_SEG_INV;
         end
         dp_d = w_dpv ^ C_DP_INV;
         // A blanked digit still lights its anode when its dp must show.
         if (!w_blank || w_dpv) begin
            an_d = (NDIG'(1) << slot_d) ^ C_AN_INV;
         end
      end
      ft_d = (slot_d == C_SLOT_MAX) && (cnt_d == C_CNT_MAX);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         slot_q <= '0;
         dig_q  <= '0;
         dpm_q  <= '0;
         lz_q   <= 1'b0;
         seg_q  <= C_SEG_INV;
         dp_q   <= C_DP_INV;
         an_q   <= C_AN_INV;
         ft_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         slot_q <= slot_d;
         dig_q  <= dig_d;
         dpm_q  <= dpm_d;
         lz_q   <= lz_d;
         seg_q  <= seg_d;
         dp_q   <= dp_d;
         an_q   <= an_d;
         ft_q   <= ft_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_tick = ft_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_mux7seg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bcd_mux7seg                                                |
// | Purpose  : Self-checking bench for bcd_mux7seg (NDIG=4, PRESCALE=8,      |
// |            BLANK_CYC=2, ACTIVE_LOW=1). Per-frame expectations are built  |
// |            from a table of hand-decoded slot values and queued; a        |
// |            monitor pops and compares one record every cycle.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bcd_mux7seg;

   logic        clk;
   logic        reset_n;
   logic [15:0] digits;
   logic [3:0]  dp_mask;
   logic        lz_blank;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_tick;

   bcd_mux7seg #(
      .NDIG       (4),
      .PRESCALE   (8),
      .BLANK_CYC  (2),
      .ACTIVE_LOW (1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .digits     (digits),
      .dp_mask    (dp_mask),
      .lz_blank   (lz_blank),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected ON-phase outputs per slot (active-low), index = slot.
   typedef struct {
      logic [15:0]     dig;
      logic [3:0]      dpm;
      logic            lz;
      logic [3:0][6:0] seg;
      logic [3:0][3:0] an;
      logic [3:0]      dpo;
   } vec_t;

   typedef struct {
      int          slot;
      int          cnt;
      logic [12:0] exp;   // {seg, dp, an, frame_tick}
   } rec_t;

   localparam logic [12:0] C_IDLE = {7'h7F, 1'b1, 4'hF, 1'b0};

   vec_t tbl [8];
   rec_t q [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic [15:0] d, input logic [3:0] m, input logic l,
                               input logic [3:0][6:0] s, input logic [3:0][3:0] a,
                               input logic [3:0] p);
      vec_t v;
      v.dig = d; v.dpm = m; v.lz = l; v.seg = s; v.an = a; v.dpo = p;
      return v;
   endfunction

   task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got seg=%h dp=%b an=%h ft=%b, want seg=%h dp=%b an=%h ft=%b",
                  name, act[12:6], act[5], act[4:1], act[0],
                  exp[12:6], exp[5], exp[4:1], exp[0]);
      end
   endtask

   task automatic apply(input vec_t v);
      digits   = v.dig;
      dp_mask  = v.dpm;
      lz_blank = v.lz;
   endtask

   // Queue one record per cycle of the coming frame, from cnt=start in slot 0.
   task automatic push_frame(input vec_t v, input int start);
      rec_t r;
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 8; c++) begin
            if (!(s == 0 && c < start)) begin
               r.slot = s;
               r.cnt  = c;
               if (c < 2) r.exp = {7'h7F, 1'b1, 4'hF, 1'b0};
               else       r.exp = {v.seg[s], v.dpo[s], v.an[s], (s == 3 && c == 7)};
               q.push_back(r);
            end
         end
      end
   endtask

   task automatic wait_ft();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = (frame_tick === 1'b1);
      end
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL frame_tick_timeout: got no pulse within 40 cycles, want one per 32");
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         rec_t r;
         r = q.pop_front();
         check($sformatf("cyc_s%0d_c%0d", r.slot, r.cnt), {seg, dp, an, frame_tick}, r.exp);
      end
   end

   initial begin
      //            digits    dpm    lz    seg s3..s0                        an s3..s0                dp s3..s0
      tbl[0] = mk(16'h1234, 4'h0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, {4'h7, 4'hB, 4'hD, 4'hE}, 4'b1111);
      tbl[1] = mk(16'h0040, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h40}, {4'hF, 4'hF, 4'hD, 4'hE}, 4'b1111);
      tbl[2] = mk(16'h0000, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {4'hF, 4'hF, 4'hF, 4'hE}, 4'b1111);
      tbl[3] = mk(16'h000A, 4'h2, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h3F}, {4'hF, 4'hF, 4'hD, 4'hE}, 4'b1101);
      tbl[4] = mk(16'h5678, 4'hA, 1'b0, {7'h12, 7'h02, 7'h78, 7'h00}, {4'h7, 4'hB, 4'hD, 4'hE}, 4'b0101);
      tbl[5] = mk(16'hB090, 4'h4, 1'b1, {7'h3F, 7'h40, 7'h10, 7'h40}, {4'h7, 4'hB, 4'hD, 4'hE}, 4'b1011);
      tbl[6] = mk(16'h0000, 4'hF, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, {4'h7, 4'hB, 4'hD, 4'hE}, 4'b0000);
      tbl[7] = mk(16'h0900, 4'h8, 1'b1, {7'h7F, 7'h10, 7'h40, 7'h40}, {4'h7, 4'hB, 4'hD, 4'hE}, 4'b0111);

      reset_n = 1'b1;
      apply(tbl[0]);
      #1 reset_n = 1'b0;
      #1 check("rst_init", {seg, dp, an, frame_tick}, C_IDLE);

      // Release: cnt=0 cycle visible immediately, then queued checks from cnt=1.
      @(negedge clk);
      @(negedge clk);
      #1 reset_n = 1'b1;
      check("rel_c0", {seg, dp, an, frame_tick}, C_IDLE);
      push_frame(tbl[0], 1);
      wait_ft();

      for (int i = 0; i < 8; i++) begin
         #1;
         apply(tbl[i]);
         push_frame(tbl[i], 0);
         wait_ft();
      end

      // Tearing: change inputs during slot 2; current frame must keep 1234.
      #1;
      apply(tbl[0]);
      push_frame(tbl[0], 0);
      wait_ft();
      #1 push_frame(tbl[0], 0);
      repeat (20) @(negedge clk);
      #1 apply(tbl[4]);
      wait_ft();
      #1 push_frame(tbl[4], 0);
      wait_ft();

      // Reset asserted during the ON phase of slot 0.
      #1;
      apply(tbl[0]);
      push_frame(tbl[0], 0);
      wait_ft();
      #1 push_frame(tbl[0], 0);
      repeat (5) @(negedge clk);
      #1 reset_n = 1'b0;
      q.delete();
      #1 check("rst_mid", {seg, dp, an, frame_tick}, C_IDLE);
      @(negedge clk);
      check("rst_hold", {seg, dp, an, frame_tick}, C_IDLE);
      @(negedge clk);
      #1 reset_n = 1'b1;
      check("rel2_c0", {seg, dp, an, frame_tick}, C_IDLE);
      push_frame(tbl[0], 1);
      wait_ft();

      #1;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL queue_drain: got %0d pending records, want 0", q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
